// File: rtl/axi_lite_regfile_pkg.sv
// Shared constants, response codes and FSM state types for the AXI-Lite register file.
package axi_lite_regfile_pkg;

  localparam int          REG_COUNT    = 8;
  localparam int          REG_IDX_W    = 3;
  localparam logic [2:0]  WR_COUNT_IDX = 3'd7;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_lite_regfile_wr.sv
// Write channel: independent AW/W capture, commit generation and B response.
// Byte-lane masking is enabled by defining AXI_REGFILE_WSTRB_EN.
module axi_lite_regfile_wr
  import axi_lite_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic [DATA_WIDTH/8:0]  wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic                   bresp,
  output logic                   bvalid,
  input  logic                   bready,
  output logic                   commit,
  output logic [REG_IDX_W-1:0]   commit_idx,
  output logic [DATA_WIDTH-1:0]  commit_data,
  output logic [DATA_WIDTH-1:0]  commit_mask
);

  localparam int STRB_W = DATA_WIDTH / 8;

  wr_state_e             state_q, state_d;
  logic                  alive_q, alive_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  bresp_q, bresp_d;
  logic                  aw_hs_s, w_hs_s, go_s, err_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic [DATA_WIDTH-1:0] mask_s;
  logic                  unused_s;

  assign awready = alive_q && (state_q == W_IDLE) && !aw_held_q;
  assign wready  = alive_q && (state_q == W_IDLE) && !w_held_q;
  assign bvalid  = (state_q == W_RESP);
  assign bresp   = bresp_q;
  assign aw_hs_s = awvalid && awready;
  assign w_hs_s  = wvalid && wready;

  // A channel not yet held is taken straight from the bus so AW+W together commit in one edge
  assign addr_s = aw_held_q ? awaddr_q : awaddr;
  assign data_s = w_held_q ? wdata_q : wdata;
  assign err_s  = (addr_s >= ADDR_WIDTH'(4 * REG_COUNT)) || (addr_s[1:0] != 2'b00) ||
                  (addr_s[4:2] == WR_COUNT_IDX);
  assign go_s   = (state_q == W_IDLE) && (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s);

`ifdef AXI_REGFILE_WSTRB_EN
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [STRB_W-1:0] strb_s;

  assign strb_s   = w_held_q ? wstrb_q : wstrb[STRB_W-1:0];
  assign unused_s = wstrb[STRB_W];

  // Expand the per-byte strobes into a bit mask
  always_comb begin
    mask_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < STRB_W; i++) begin
      mask_s[8*i +: 8] = {8{strb_s[i]}};
    end
  end

  // Strobe holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstrb_q <= {STRB_W{1'b0}};
    end else begin
      wstrb_q <= wstrb_d;
    end
  end

  // Strobes travel with the data beat
  always_comb begin
    wstrb_d = wstrb_q;
    if (w_hs_s) begin
      wstrb_d = wstrb[STRB_W-1:0];
    end else begin
      wstrb_d = wstrb_q;
    end
  end
`else
  assign mask_s   = {DATA_WIDTH{1'b1}};
  assign unused_s = ^wstrb;
`endif

  assign commit      = go_s && !err_s;
  assign commit_idx  = addr_s[4:2];
  assign commit_data = data_s;
  assign commit_mask = mask_s;

  // Write FSM and holding register update
  always_comb begin
    state_d   = state_q;
    alive_d   = 1'b1;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    bresp_d   = bresp_q;
    case (state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end else begin
          aw_held_d = aw_held_q;
        end
        if (w_hs_s) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
        end else begin
          w_held_d = w_held_q;
        end
        if (go_s) begin
          state_d = W_RESP;
          bresp_d = err_s ? RESP_SLVERR : RESP_OKAY;
        end else begin
          state_d = W_IDLE;
        end
      end
      W_RESP: begin
        if (bready) begin
          state_d   = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end else begin
          state_d = W_RESP;
        end
      end
      default: begin
        state_d   = W_IDLE;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
      end
    endcase
  end

  // Write-side state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= W_IDLE;
      alive_q   <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= {ADDR_WIDTH{1'b0}};
      wdata_q   <= {DATA_WIDTH{1'b0}};
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register file: seven R/W words plus a read-only write counter at word 7.
// Optional byte-strobe masking is selected with AXI_REGFILE_WSTRB_EN.
module axi_lite_regfile
  import axi_lite_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                            s0_axi_aclk,
  input  logic                            s0_axi_areset,
  input  logic [ADDR_WIDTH-1:0]           s0_axi_awaddr,
  input  logic                            s0_axi_awvalid,
  output logic                            s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]           s0_axi_wdata,
  input  logic [DATA_WIDTH/8:0]           s0_axi_wstrb,
  input  logic                            s0_axi_wvalid,
  output logic                            s0_axi_wready,
  output logic                            s0_axi_bresp,
  output logic                            s0_axi_bvalid,
  input  logic                            s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]           s0_axi_araddr,
  input  logic                            s0_axi_arvalid,
  output logic                            s0_axi_arready,
  output logic [DATA_WIDTH-1:0]           s0_axi_rdata,
  output logic                            s0_axi_rresp,
  output logic                            s0_axi_rvalid,
  input  logic                            s0_axi_rready,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out
);

  logic                  commit_s;
  logic [REG_IDX_W-1:0]  commit_idx_s;
  logic [DATA_WIDTH-1:0] commit_data_s;
  logic [DATA_WIDTH-1:0] commit_mask_s;

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

  rd_state_e             rstate_q, rstate_d;
  logic                  alive_q, alive_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rresp_q, rresp_d;
  logic                  ar_hs_s, rd_err_s;

  axi_lite_regfile_wr #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr (
    .clk         (s0_axi_aclk),
    .rst         (s0_axi_areset),
    .awaddr      (s0_axi_awaddr),
    .awvalid     (s0_axi_awvalid),
    .awready     (s0_axi_awready),
    .wdata       (s0_axi_wdata),
    .wstrb       (s0_axi_wstrb),
    .wvalid      (s0_axi_wvalid),
    .wready      (s0_axi_wready),
    .bresp       (s0_axi_bresp),
    .bvalid      (s0_axi_bvalid),
    .bready      (s0_axi_bready),
    .commit      (commit_s),
    .commit_idx  (commit_idx_s),
    .commit_data (commit_data_s),
    .commit_mask (commit_mask_s)
  );

  // Masked word update; only OKAY writes reach here, so the counter always advances with them
  always_comb begin
    regs_d = regs_q;
    if (commit_s) begin
      regs_d[commit_idx_s] = (regs_q[commit_idx_s] & ~commit_mask_s) |
                             (commit_data_s & commit_mask_s);
      regs_d[WR_COUNT_IDX] = regs_q[WR_COUNT_IDX] + DATA_WIDTH'(1);
    end else begin
      regs_d = regs_q;
    end
  end

  // Register array
  always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
    if (s0_axi_areset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Flat export of all words, word 0 in the LSBs
  always_comb begin
    reg_out = {(REG_COUNT*DATA_WIDTH){1'b0}};
    for (int i = 0; i < REG_COUNT; i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign s0_axi_arready = alive_q && (rstate_q == R_IDLE);
  assign s0_axi_rvalid  = (rstate_q == R_DATA);
  assign s0_axi_rdata   = rdata_q;
  assign s0_axi_rresp   = rresp_q;
  assign ar_hs_s        = s0_axi_arvalid && s0_axi_arready;
  assign rd_err_s       = (s0_axi_araddr >= ADDR_WIDTH'(4 * REG_COUNT)) ||
                          (s0_axi_araddr[1:0] != 2'b00);

  // Read FSM; sampling regs_q gives the pre-write value when a commit lands on the same edge
  always_comb begin
    rstate_d = rstate_q;
    alive_d  = 1'b1;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rstate_d = R_DATA;
          rdata_d  = rd_err_s ? {DATA_WIDTH{1'b0}} : regs_q[s0_axi_araddr[4:2]];
          rresp_d  = rd_err_s ? RESP_SLVERR : RESP_OKAY;
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (s0_axi_rready) begin
          rstate_d = R_IDLE;
        end else begin
          rstate_d = R_DATA;
        end
      end
      default: begin
        rstate_d = R_IDLE;
      end
    endcase
  end

  // Read-side state registers
  always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
    if (s0_axi_areset) begin
      rstate_q <= R_IDLE;
      alive_q  <= 1'b0;
      rdata_q  <= {DATA_WIDTH{1'b0}};
      rresp_q  <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      alive_q  <= alive_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scoreboard bench for axi_lite_regfile: random AXI-Lite traffic against an array-based reference model.
module tb_axi_lite_regfile;

`ifdef AXI_REGFILE_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   awaddr = 8'h00;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = 32'h0;
  logic [4:0]   wstrb = 5'h0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic         bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [7:0]   araddr = 8'h00;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic         rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [255:0] reg_out;

  int compared = 0;
  int mismatched = 0;
  bit hold_b = 1'b0;
  bit hold_r = 1'b0;

  logic [31:0] mdl [7];
  logic [31:0] mcnt;
  logic        bq [$];
  logic [32:0] rq [$];

  axi_lite_regfile dut (
    .s0_axi_aclk    (clk),
    .s0_axi_areset  (rst),
    .s0_axi_awaddr  (awaddr),
    .s0_axi_awvalid (awvalid),
    .s0_axi_awready (awready),
    .s0_axi_wdata   (wdata),
    .s0_axi_wstrb   (wstrb),
    .s0_axi_wvalid  (wvalid),
    .s0_axi_wready  (wready),
    .s0_axi_bresp   (bresp),
    .s0_axi_bvalid  (bvalid),
    .s0_axi_bready  (bready),
    .s0_axi_araddr  (araddr),
    .s0_axi_arvalid (arvalid),
    .s0_axi_arready (arready),
    .s0_axi_rdata   (rdata),
    .s0_axi_rresp   (rresp),
    .s0_axi_rvalid  (rvalid),
    .s0_axi_rready  (rready),
    .reg_out        (reg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: word index is addr/4, word 7 is the OKAY-write counter
  function automatic bit addr_bad(input logic [7:0] a);
    return (a >= 8'd32) || (a % 8'd4 != 8'd0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) mdl[i] = 32'h0;
    mcnt = 32'h0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
    bit err;
    int idx;
    err = addr_bad(a) || (a / 8'd4 == 8'd7);
    idx = int'(a) / 4;
    if (!err) begin
      for (int i = 0; i < 4; i++) begin
        if (!STRB_EN || s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
      end
      mcnt = mcnt + 32'd1;
    end
    bq.push_back(err);
  endtask

  task automatic model_read(input logic [7:0] a);
    logic [31:0] v;
    bit err;
    int idx;
    err = addr_bad(a);
    idx = int'(a) / 4;
    if (err) v = 32'h0;
    else if (idx == 7) v = mcnt;
    else v = mdl[idx];
    rq.push_back({err, v});
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 7; i++) f[32*i +: 32] = mdl[i];
    f[255:224] = mcnt;
    return f;
  endfunction

  // Monitor: pops the scoreboard on every completed B or R handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) check("b_unexpected", 256'd1, 256'd0);
        else check("bresp", {255'd0, bresp}, {255'd0, bq.pop_front()});
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) check("r_unexpected", 256'd1, 256'd0);
        else check("rresp_rdata", {223'd0, rresp, rdata}, {223'd0, rq.pop_front()});
      end
    end
  end

  // Random back-pressure on B and R
  initial begin
    forever begin
      @(posedge clk);
      #1;
      bready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
      rready = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_aw(input logic [7:0] a, input int dly);
    bit ok = 1'b0;
    repeat (dly) tick();
    awaddr = a;
    awvalid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    tick();
    awvalid = 1'b0;
    check("aw_handshake", {255'd0, ok}, 256'd1);
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [4:0] s, input int dly);
    bit ok = 1'b0;
    repeat (dly) tick();
    wdata = d;
    wstrb = s;
    wvalid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wready) begin ok = 1'b1; break; end
    end
    tick();
    wvalid = 1'b0;
    check("w_handshake", {255'd0, ok}, 256'd1);
  endtask

  task automatic drive_ar(input logic [7:0] a, input int dly);
    bit ok = 1'b0;
    repeat (dly) tick();
    araddr = a;
    arvalid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    tick();
    arvalid = 1'b0;
    check("ar_handshake", {255'd0, ok}, 256'd1);
  endtask

  task automatic wait_b();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bvalid && bready) begin ok = 1'b1; break; end
    end
    tick();
    check("b_timeout", {255'd0, ok}, 256'd1);
  endtask

  task automatic wait_r();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rvalid && rready) begin ok = 1'b1; break; end
    end
    tick();
    check("r_timeout", {255'd0, ok}, 256'd1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                          input int da, input int dw);
    model_write(a, d, s);
    fork
      drive_aw(a, da);
      drive_w(d, s, dw);
    join
    wait_b();
    check("reg_out", reg_out, model_flat());
  endtask

  task automatic do_read(input logic [7:0] a, input int dly);
    model_read(a);
    drive_ar(a, dly);
    wait_r();
  endtask

  function automatic logic [7:0] rand_addr();
    int r;
    r = $urandom_range(0, 11);
    if (r < 8) return 8'(r * 4);
    else if (r < 10) return 8'($urandom_range(0, 31));
    else return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    model_reset();
    #23;
    check("rst_ready", {253'd0, awready, wready, arready}, 256'd0);
    check("rst_valid", {254'd0, bvalid, rvalid}, 256'd0);
    check("rst_data", {222'd0, bresp, rresp, rdata}, 256'd0);
    check("rst_regs", reg_out, 256'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", {253'd0, awready, wready, arready}, 256'd7);

    // Basic write then readback including the counter
    do_write(8'h00, 32'h17, 5'h0F, 0, 0);
    do_read(8'h00, 0);
    do_read(8'h1C, 0);

    // AW leads W; B follows the W handshake edge
    hold_b = 1'b1;
    model_write(8'h04, 32'h1E, 5'h0F);
    drive_aw(8'h04, 0);
    tick();
    tick();
    check("aw_held_no_b", {253'd0, bvalid, awready, wready}, 256'd1);
    drive_w(32'h1E, 5'h0F, 0);
    check("b_latency", {255'd0, bvalid}, 256'd1);

    // B back-pressure blocks the write channel
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b_stall", {253'd0, bvalid, awready, wready}, 256'd4);
    end
    hold_b = 1'b0;
    wait_b();
    do_read(8'h04, 1);

    // Decode errors and the read-only counter
    do_write(8'h20, 32'hDEAD_BEEF, 5'h0F, 0, 0);
    do_read(8'h20, 0);
    do_write(8'h1C, 32'h1234_5678, 5'h0F, 0, 1);
    do_write(8'h0A, 32'h5555_AAAA, 5'h0F, 1, 0);
    do_read(8'h1D, 0);
    do_read(8'h1C, 0);

    // Byte strobes
    do_write(8'h14, 32'hAABB_CCDD, 5'h0F, 0, 0);
    do_write(8'h14, 32'h1122_3344, 5'h05, 0, 0);
    do_read(8'h14, 0);
    do_write(8'h18, 32'h0F0F_0F0F, 5'h10, 0, 0);
    do_read(8'h18, 0);

    // Same-edge write and read of one word: read sees the old value
    model_read(8'h08);
    model_write(8'h08, 32'hCAFE_F00D, 5'h0F);
    fork
      drive_aw(8'h08, 0);
      drive_w(32'hCAFE_F00D, 5'h0F, 0);
      drive_ar(8'h08, 0);
    join
    fork
      wait_b();
      wait_r();
    join
    do_read(8'h08, 0);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 2))
        0: do_write(rand_addr(), $urandom, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        1: do_read(rand_addr(), $urandom_range(0, 2));
        default: begin
          logic [7:0] a;
          logic [31:0] d;
          a = rand_addr();
          d = $urandom;
          model_read(a);
          model_write(a, d, 5'h0F);
          fork
            drive_aw(a, 0);
            drive_w(d, 5'h0F, 0);
            drive_ar(a, 0);
          join
          fork
            wait_b();
            wait_r();
          join
        end
      endcase
    end
    do_read(8'h1C, 0);

    // Reset while a read response is pending
    hold_r = 1'b1;
    drive_ar(8'h08, 0);
    @(negedge clk);
    check("rvalid_pending", {255'd0, rvalid}, 256'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {254'd0, bvalid, rvalid}, 256'd0);
    check("rst_mid_ready", {253'd0, awready, wready, arready}, 256'd0);
    check("rst_mid_data", {222'd0, bresp, rresp, rdata}, 256'd0);
    check("rst_mid_regs", reg_out, 256'd0);
    rq.delete();
    bq.delete();
    model_reset();
    hold_r = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("ready_after_rst2", {253'd0, awready, wready, arready}, 256'd7);
    do_read(8'h08, 0);
    do_read(8'h1C, 0);

    repeat (3) tick();
    check("queues_drained", 256'(bq.size() + rq.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
